// File: rtl/cryptoveril_seq_ctrl_if.sv
// rtl/cryptoveril_seq_ctrl_if.sv - host request/response bundle for the cipher sequencer
// Purpose: groups the host-side request and response handshakes.
// Ports (signals):
//   req_valid/req_ready/req_data/req_key  request channel, host -> controller
//   rsp_valid/rsp_ready/rsp_data          response channel, controller -> host
// Modports: master = host side, slave = controller side.
interface cryptoveril_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [KEY_W-1:0]  req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_data, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cryptoveril_seq_ctrl.sv
// rtl/cryptoveril_seq_ctrl.sv - sequencer for the stage1 -> stage2 -> stage3 cipher pipeline
// Purpose: accepts one word/key request, pulses stage1 ld/start, waits for the
// synchronised stage1/stage2 done events (each guarded by a timeout), waits
// S3_LAT cycles for stage3, then returns the captured result to the host.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   host          request/response handshakes (slave modport)
//   ld, start     stage1 load/start one-cycle pulses
//   stg_data/key  word and key held for the whole operation
//   stg1/2_done   done levels from a foreign clock domain
//   s3_result     stage3 output word
//   busy          high in any state except IDLE
//   timeout_err   one-cycle pulse when a wait state times out
module cryptoveril_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int KEY_W   = 5,
  parameter int TIMEOUT = 255,
  parameter int S3_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  cryptoveril_seq_ctrl_if.slave host,
  output logic                ld,
  output logic                start,
  output logic [DATA_W-1:0]   stg_data,
  output logic [KEY_W-1:0]    stg_key,
  input  logic                stg1_done,
  input  logic                stg2_done,
  input  logic [DATA_W-1:0]   s3_result,
  output logic                busy,
  output logic                timeout_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = (S3_LAT > 1) ? $clog2(S3_LAT) : 1;
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [CW-1:0] C_INIT = CW'(S3_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT1, S_WAIT2, S_DRAIN, S_RESP, S_ERR
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [CW-1:0] drain_cnt;
  logic          pending;

  // [1:0] is the two-flop synchroniser, [2] remembers the previous synced
  // level so only a 0->1 transition produces an event.
  logic [2:0] s1_sync, s2_sync;
  logic       s1_ev, s2_ev;

  assign timer_inc = (timer == T_MAX) ? timer : timer + TW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sync <= '0;
      s2_sync <= '0;
      s1_ev   <= 1'b0;
      s2_ev   <= 1'b0;
    end else begin
      s1_sync <= {s1_sync[1:0], stg1_done};
      s2_sync <= {s2_sync[1:0], stg2_done};
      s1_ev   <= s1_sync[1] & ~s1_sync[2];
      s2_ev   <= s2_sync[1] & ~s2_sync[2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      host.req_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      ld             <= 1'b0;
      start          <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      stg_data       <= '0;
      stg_key        <= '0;
      timer          <= '0;
      drain_cnt      <= '0;
      pending        <= 1'b0;
    end else begin
      ld          <= 1'b0;
      start       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host.req_valid) begin
            stg_data       <= host.req_data;
            stg_key        <= host.req_key;
            host.req_ready <= 1'b0;
            busy           <= 1'b1;
            ld             <= 1'b1;
            state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          start <= 1'b1;
          state <= S_START;
        end
        S_START: begin
          timer   <= '0;
          pending <= 1'b0;
          state   <= S_WAIT1;
        end
        S_WAIT1: begin
          // stage2 may finish first; remember it for WAIT2.
          if (s2_ev) pending <= 1'b1;
          // The done event is tested before the timeout so it wins a tie.
          if (s1_ev) begin
            timer <= '0;
            state <= S_WAIT2;
          end else if (timer == T_MAX) begin
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            timer <= timer_inc;
          end
        end
        S_WAIT2: begin
          if (s2_ev || pending) begin
            pending   <= 1'b0;
            drain_cnt <= C_INIT;
            state     <= S_DRAIN;
          end else if (timer == T_MAX) begin
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            host.rsp_data  <= s3_result;
            host.rsp_valid <= 1'b1;
            state          <= S_RESP;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (host.rsp_valid && host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            host.req_ready <= 1'b1;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end
        end
        S_ERR: begin
          pending        <= 1'b0;
          host.req_ready <= 1'b1;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          host.req_ready <= 1'b1;
          busy           <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cryptoveril_seq_ctrl.sv
// tb/tb_cryptoveril_seq_ctrl.sv - directed self-checking bench for cryptoveril_seq_ctrl
module tb_cryptoveril_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld, start, busy, timeout_err;
  logic [15:0] stg_data;
  logic [4:0]  stg_key;
  logic        stg1_done = 1'b0;
  logic        stg2_done = 1'b0;
  logic [15:0] s3_result = '0;

  int n_cmp = 0;
  int n_bad = 0;

  cryptoveril_seq_ctrl_if #(.DATA_W(16), .KEY_W(5)) host ();

  cryptoveril_seq_ctrl #(.DATA_W(16), .KEY_W(5), .TIMEOUT(8), .S3_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host.slave),
    .ld          (ld),
    .start       (start),
    .stg_data    (stg_data),
    .stg_key     (stg_key),
    .stg1_done   (stg1_done),
    .stg2_done   (stg2_done),
    .s3_result   (s3_result),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents a request for one edge; afterwards the DUT is in LOAD (edge A).
  task automatic send_req(input string tag, input logic [15:0] d, input logic [4:0] k);
    check({tag, "_req_ready"}, 32'(host.req_ready), 32'd1);
    host.req_valid = 1'b1;
    host.req_data  = d;
    host.req_key   = k;
    tick();
    host.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int max);
    int n = 0;
    while (!host.rsp_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(host.rsp_valid), 32'd1);
  endtask

  initial begin
    host.req_valid = 1'b0;
    host.req_data  = '0;
    host.req_key   = '0;
    host.rsp_ready = 1'b0;

    // Reset state
    ticks(2);
    check("rst_req_ready", 32'(host.req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_start", {30'd0, ld, start}, 32'd0);
    check("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(host.rsp_data), 32'd0);
    check("rst_stg", {11'd0, stg_key, stg_data}, 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    ticks(2);

    // 1. Nominal: stg1 5 cycles after start, stg2 4 later, rsp at A+16
    send_req("nom", 16'hA5C3, 5'h1B);
    check("nom_ld", {30'd0, ld, start}, 32'd2);
    check("nom_busy_load", 32'(busy), 32'd1);
    check("nom_req_ready_low", 32'(host.req_ready), 32'd0);
    check("nom_stg_data", 32'(stg_data), 32'hA5C3);
    check("nom_stg_key", 32'(stg_key), 32'h1B);
    tick();
    check("nom_start", {30'd0, ld, start}, 32'd1);
    tick();
    check("nom_pulses_off", {30'd0, ld, start}, 32'd0);
    ticks(4);
    stg1_done = 1'b1;
    ticks(4);
    stg2_done = 1'b1;
    s3_result = 16'h3C5A;
    ticks(5);
    check("nom_rsp_not_early", 32'(host.rsp_valid), 32'd0);
    check("nom_busy_drain", 32'(busy), 32'd1);
    tick();
    check("nom_rsp_valid", 32'(host.rsp_valid), 32'd1);
    check("nom_rsp_data", 32'(host.rsp_data), 32'h3C5A);

    // 2. Backpressure with a competing request
    host.req_valid = 1'b1;
    host.req_data  = 16'hFFFF;
    host.req_key   = 5'h1F;
    s3_result      = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_rsp_valid", 32'(host.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(host.rsp_data), 32'h3C5A);
      check("bp_req_ready", 32'(host.req_ready), 32'd0);
    end
    host.rsp_ready = 1'b1;
    tick();
    check("bp_idle_req_ready", 32'(host.req_ready), 32'd1);
    check("bp_idle_rsp_valid", 32'(host.rsp_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_stg_held", {11'd0, stg_key, stg_data}, {11'd0, 5'h1B, 16'hA5C3});
    host.req_valid = 1'b0;
    stg1_done = 1'b0;
    stg2_done = 1'b0;
    ticks(4);

    // 3. Timeout in WAIT1: error pulse after 9 WAIT1 cycles (A+11)
    send_req("to", 16'h1111, 5'h01);
    ticks(10);
    check("to_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 32'd1);
    check("to_no_rsp", 32'(host.rsp_valid), 32'd0);
    tick();
    check("to_err_cleared", 32'(timeout_err), 32'd0);
    check("to_req_ready", 32'(host.req_ready), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_no_rsp2", 32'(host.rsp_valid), 32'd0);

    // 4. Early stg2: pending flag carries it, rsp at A+13
    send_req("early", 16'h0F0F, 5'h03);
    ticks(2);
    stg2_done = 1'b1;
    s3_result = 16'h1234;
    ticks(4);
    stg1_done = 1'b1;
    ticks(6);
    check("early_rsp_not_early", 32'(host.rsp_valid), 32'd0);
    tick();
    check("early_rsp_valid", 32'(host.rsp_valid), 32'd1);
    check("early_rsp_data", 32'(host.rsp_data), 32'h1234);
    tick();
    check("early_back_idle", 32'(host.req_ready), 32'd1);
    stg1_done = 1'b0;
    stg2_done = 1'b0;
    ticks(4);

    // 6a. stg1 event on the timer==TIMEOUT cycle (A+11): done wins
    send_req("tie", 16'hBEEF, 5'h15);
    ticks(7);
    stg1_done = 1'b1;
    ticks(4);
    check("tie_no_err", 32'(timeout_err), 32'd0);
    check("tie_busy", 32'(busy), 32'd1);
    tick();
    check("tie_no_err2", 32'(timeout_err), 32'd0);
    check("tie_still_busy", 32'(busy), 32'd1);
    stg2_done = 1'b1;
    s3_result = 16'h5A5A;
    wait_rsp("tie_rsp_seen", 20);
    check("tie_rsp_data", 32'(host.rsp_data), 32'h5A5A);
    tick();
    check("tie_back_idle", 32'(host.req_ready), 32'd1);
    stg2_done = 1'b0;
    ticks(4);

    // 6b. stg1_done still high from the previous op: no edge -> timeout
    send_req("held", 16'h4321, 5'h07);
    ticks(10);
    check("held_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    check("held_err_pulse", 32'(timeout_err), 32'd1);
    check("held_no_rsp", 32'(host.rsp_valid), 32'd0);
    tick();
    check("held_req_ready", 32'(host.req_ready), 32'd1);
    stg1_done = 1'b0;
    ticks(4);

    // 5. Reset asserted in WAIT2, between clock edges
    send_req("mid", 16'h7777, 5'h11);
    ticks(6);
    stg1_done = 1'b1;
    ticks(6);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(host.req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stg", {11'd0, stg_key, stg_data}, 32'd0);
    check("mid_rst_rsp_data", 32'(host.rsp_data), 32'd0);
    check("mid_rst_outs", {28'd0, ld, start, host.rsp_valid, timeout_err}, 32'd0);
    stg1_done = 1'b0;
    ticks(2);
    rst = 1'b1;
    ticks(2);
    check("mid_post_no_err", 32'(timeout_err), 32'd0);
    send_req("post", 16'h2468, 5'h0A);
    tick();
    ticks(5);
    stg1_done = 1'b1;
    ticks(4);
    stg2_done = 1'b1;
    s3_result = 16'h8642;
    wait_rsp("post_rsp_seen", 20);
    check("post_rsp_data", 32'(host.rsp_data), 32'h8642);
    check("post_stg_data", 32'(stg_data), 32'h2468);
    tick();
    check("post_back_idle", 32'(host.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
